// File: rtl/aidan_mcnay_debounce.sv
// rtl/aidan_mcnay_debounce.sv - synchronizer plus hold-time debounce FSM for a raw button line
// Optional rejected-glitch counter: define AIDAN_MCNAY_DEBOUNCE_GLITCH_CNT_EN.
module aidan_mcnay_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_WIDTH    = 16,
    parameter int HOLD_CYCLES  = 50000,
    parameter int GLITCH_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_raw,
    output logic                    out_clean,
    output logic                    busy,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic                   out_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in_raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            out_clean <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            out_clean <= out_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        out_next   = out_clean;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    state_next = WAIT_HI;
                    cnt_next   = CNT_WIDTH'(1);
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_next = STABLE_LO;
                end else if (cnt == HOLD_LAST) begin
                    state_next = STABLE_HI;
                    out_next   = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_WIDTH'(1);
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_next = WAIT_LO;
                    cnt_next   = CNT_WIDTH'(1);
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_next = STABLE_HI;
                end else if (cnt == HOLD_LAST) begin
                    state_next = STABLE_LO;
                    out_next   = 1'b0;
                end else begin
                    cnt_next   = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_next = STABLE_LO;
                out_next   = 1'b0;
            end
        endcase
    end

    assign busy = (state == WAIT_HI) || (state == WAIT_LO);

`ifdef AIDAN_MCNAY_DEBOUNCE_GLITCH_CNT_EN
    // While waiting, s matching the stable level means the candidate was abandoned.
    logic glitch;
    assign glitch = busy && (s == out_clean);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_count <= '0;
        end else if (glitch && (glitch_count != {GLITCH_WIDTH{1'b1}})) begin
            glitch_count <= glitch_count + GLITCH_WIDTH'(1);
        end
    end
`else
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_aidan_mcnay_debounce.sv
// tb/tb_aidan_mcnay_debounce.sv - scoreboard bench for aidan_mcnay_debounce (SYNC_STAGES=2, HOLD_CYCLES=4)
module tb_aidan_mcnay_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_raw;
    logic       out_clean;
    logic       busy;
    logic [1:0] glitch_count;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] exp_gc = 2'd0;

    typedef struct {
        string      tag;
        logic       oc;
        logic       bsy;
        logic [1:0] gc;
    } exp_t;

    exp_t sb[$];

    aidan_mcnay_debounce #(
        .SYNC_STAGES (2),
        .CNT_WIDTH   (16),
        .HOLD_CYCLES (4),
        .GLITCH_WIDTH(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_raw      (in_raw),
        .out_clean   (out_clean),
        .busy        (busy),
        .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic oc, input logic bsy);
        exp_t e;
        e.tag = tag;
        e.oc  = oc;
        e.bsy = bsy;
        e.gc  = exp_gc;
        sb.push_back(e);
    endtask

    // Independent model of the optional counter: one per rejected candidate, saturating.
    task automatic note_glitch();
`ifdef AIDAN_MCNAY_DEBOUNCE_GLITCH_CNT_EN
        if (exp_gc != 2'd3) exp_gc = exp_gc + 2'd1;
`endif
    endtask

    task automatic check();
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            assert (out_clean === e.oc) else begin
                miscompares++;
                $error("FAIL %s.out_clean: observed %b expected %b", e.tag, out_clean, e.oc);
            end
            vectors++;
            assert (busy === e.bsy) else begin
                miscompares++;
                $error("FAIL %s.busy: observed %b expected %b", e.tag, busy, e.bsy);
            end
            vectors++;
            assert (glitch_count === e.gc) else begin
                miscompares++;
                $error("FAIL %s.glitch_count: observed %0d expected %0d", e.tag, glitch_count, e.gc);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        in_raw = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        push("idle", 1'b0, 1'b0);
        check();

        // Clean press: edge 0 is the next posedge after in_raw rises.
        in_raw = 1'b1;
        push("press_e1", 1'b0, 1'b0);
        tick(2);
        check();
        push("press_e2", 1'b0, 1'b1);
        tick(1);
        check();
        push("press_e4", 1'b0, 1'b1);
        tick(2);
        check();
        push("press_e5", 1'b1, 1'b0);
        tick(1);
        check();

        // Release held low.
        in_raw = 1'b0;
        push("release_e4", 1'b1, 1'b1);
        tick(5);
        check();
        push("release_e5", 1'b0, 1'b0);
        tick(1);
        check();

        // Bounce: three cycles high then back low.
        in_raw = 1'b1;
        tick(3);
        in_raw = 1'b0;
        push("bounce_wait", 1'b0, 1'b1);
        check();
        note_glitch();
        push("bounce_abort", 1'b0, 1'b0);
        tick(3);
        check();

        // Go high cleanly, then a one-cycle low pulse must be ignored.
        in_raw = 1'b1;
        push("high_again", 1'b1, 1'b0);
        tick(8);
        check();
        in_raw = 1'b0;
        tick(1);
        in_raw = 1'b1;
        note_glitch();
        push("low_pulse", 1'b1, 1'b0);
        tick(5);
        check();

        // Return low, then reset mid-qualification at cnt=2.
        in_raw = 1'b0;
        push("low_again", 1'b0, 1'b0);
        tick(8);
        check();
        in_raw = 1'b1;
        push("midq_busy", 1'b0, 1'b1);
        tick(4);
        check();
        rst_n = 1'b0;
        #1;
        exp_gc = 2'd0;
        push("async_reset", 1'b0, 1'b0);
        check();
        @(negedge clk);
        tick(1);
        push("in_reset", 1'b0, 1'b0);
        check();
        @(negedge clk);
        rst_n = 1'b1;
        push("post_rst_e4", 1'b0, 1'b1);
        tick(5);
        check();
        push("post_rst_e5", 1'b1, 1'b0);
        tick(1);
        check();

        // Saturation: five rejected low pulses while high.
        for (int k = 0; k < 5; k++) begin
            in_raw = 1'b0;
            tick(1);
            in_raw = 1'b1;
            note_glitch();
            push($sformatf("sat_%0d", k), 1'b1, 1'b0);
            tick(5);
            check();
        end
        push("sat_hold", 1'b1, 1'b0);
        tick(10);
        check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
